// File: rtl/mem_port_master.sv
// Single-word load/store initiator for one port of the two-port 16-bit memory.
// Define MEM_BURST_EN to enable two-word burst loads (addr, addr+1).
module mem_port_master #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 65535
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic              i_req_burst,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_data,
  output logic              o_wr_done,
  output logic              o_resp_err,
  output logic [ADDR_W-1:0] o_mem_A,
  output logic [DATA_W-1:0] o_mem_W,
  output logic              o_mem_write,
  output logic              o_mem_read,
  input  logic [DATA_W-1:0] i_mem_R
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_ACCESS2,
    S_WAIT2
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  state_t              r_state;
  logic                r_req_ready;
  logic                r_write;
  logic                r_resp_valid;
  logic                r_wr_done;
  logic                r_resp_err;
  logic                r_mem_write;
  logic                r_mem_read;
  logic [DATA_W-1:0]   r_resp_data;
  logic [DATA_W-1:0]   r_mem_W;
  logic [ADDR_W-1:0]   r_mem_A;

  logic                w_accept;
  logic                w_in_range;

  assign w_accept   = i_req_valid & r_req_ready;
  assign w_in_range = ({1'b0, i_req_addr} < LP_DEPTH);

`ifdef MEM_BURST_EN
  logic                r_burst;
  logic                r_skip;
  logic [ADDR_W:0]     w_next_addr;

  // One bit wider so addr+1 past the top of the address space is still detectable
  assign w_next_addr = {1'b0, r_mem_A} + (ADDR_W+1)'(1);
`else
  logic                w_unused_burst;

  assign w_unused_burst = i_req_burst;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_write      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_wr_done    <= 1'b0;
      r_resp_err   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_resp_data  <= '0;
      r_mem_W      <= '0;
      r_mem_A      <= '0;
`ifdef MEM_BURST_EN
      r_burst      <= 1'b0;
      r_skip       <= 1'b0;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      r_wr_done    <= 1'b0;
      r_resp_err   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write <= i_req_write;
            r_mem_A <= i_req_addr;
            r_mem_W <= i_req_wdata;
`ifdef MEM_BURST_EN
            r_burst <= i_req_burst & ~i_req_write;
            r_skip  <= 1'b0;
`endif
            // Out-of-range commands are answered from IDLE without touching the memory
            if (!w_in_range) begin
              r_resp_err <= 1'b1;
            end else begin
              r_state     <= S_ACCESS;
              r_req_ready <= 1'b0;
              r_mem_write <= i_req_write;
              r_mem_read  <= ~i_req_write;
            end
          end
        end
        S_ACCESS: begin
          if (r_write) begin
            r_wr_done   <= 1'b1;
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_resp_data  <= i_mem_R;
          r_resp_valid <= 1'b1;
`ifdef MEM_BURST_EN
          if (r_burst) begin
            r_state <= S_ACCESS2;
            if (w_next_addr >= LP_DEPTH) begin
              r_skip <= 1'b1;
            end else begin
              r_mem_A    <= w_next_addr[ADDR_W-1:0];
              r_mem_read <= 1'b1;
            end
          end else begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end
`else
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
`endif
        end
`ifdef MEM_BURST_EN
        S_ACCESS2: begin
          r_state <= S_WAIT2;
        end
        S_WAIT2: begin
          // A skipped second beat reports an error in the slot its data would have used
          if (r_skip) begin
            r_resp_err <= 1'b1;
          end else begin
            r_resp_data  <= i_mem_R;
            r_resp_valid <= 1'b1;
          end
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
`endif
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_wr_done    = r_wr_done;
  assign o_resp_err   = r_resp_err;
  assign o_mem_A      = r_mem_A;
  assign o_mem_W      = r_mem_W;
  assign o_mem_write  = r_mem_write;
  assign o_mem_read   = r_mem_read;

endmodule

// File: tb/tb_mem_port_master.sv
// Randomized self-checking bench for mem_port_master with a transaction-level reference model
// and a registered-read memory attached to the port. Burst checks run when MEM_BURST_EN is defined.
module tb_mem_port_master;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 65535;

  logic              clk;
  logic              reset;
  logic              reqValid;
  logic              reqReady;
  logic              reqWrite;
  logic              reqBurst;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqWdata;
  logic              respValid;
  logic [DATA_W-1:0] respData;
  logic              wrDone;
  logic              respErr;
  logic [ADDR_W-1:0] memA;
  logic [DATA_W-1:0] memW;
  logic              memWrite;
  logic              memRead;
  logic [DATA_W-1:0] memR;

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] envMem [0:65535];
  logic [DATA_W-1:0] refMem [int];
  logic [DATA_W-1:0] lastData;

  mem_port_master #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req_valid (reqValid),
    .o_req_ready (reqReady),
    .i_req_write (reqWrite),
    .i_req_burst (reqBurst),
    .i_req_addr  (reqAddr),
    .i_req_wdata (reqWdata),
    .o_resp_valid(respValid),
    .o_resp_data (respData),
    .o_wr_done   (wrDone),
    .o_resp_err  (respErr),
    .o_mem_A     (memA),
    .o_mem_W     (memW),
    .o_mem_write (memWrite),
    .o_mem_read  (memRead),
    .i_mem_R     (memR)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory seen by the port: write on the strobe edge, read data registered one edge later
  always @(posedge clk) begin
    if (memWrite) envMem[memA] <= memW;
    if (memRead)  memR <= envMem[memA];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_rv"},    respValid, 0);
    checkOutput({tag, "_wd"},    wrDone, 0);
    checkOutput({tag, "_err"},   respErr, 0);
    checkOutput({tag, "_mw"},    memWrite, 0);
    checkOutput({tag, "_mr"},    memRead, 0);
    checkOutput({tag, "_rdy"},   reqReady, 1);
    checkOutput({tag, "_data"},  respData, lastData);
  endtask

  // Issues one command (called just after a falling edge) and checks it cycle by cycle
  task automatic applyStimulus(input logic wr, input logic burst,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    logic              inRange;
    logic              isBurst;
    logic              lastBeat;
    logic [ADDR_W-1:0] addr2;
    inRange  = int'(addr) < MEM_DEPTH;
    lastBeat = (int'(addr) + 1) >= MEM_DEPTH;
    addr2    = addr + 16'd1;
`ifdef MEM_BURST_EN
    isBurst = burst && !wr;
`else
    isBurst = 1'b0;
`endif
    reqValid = 1'b1;
    reqWrite = wr;
    reqBurst = burst;
    reqAddr  = addr;
    reqWdata = data;
    checkOutput("ready_idle", reqReady, 1);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    reqWrite = 1'($urandom);
    reqBurst = 1'($urandom);
    reqAddr  = 16'($urandom);
    reqWdata = 16'($urandom);
    @(negedge clk);
    if (!inRange) begin
      checkOutput("err_pulse", respErr, 1);
      checkOutput("err_no_wr", memWrite, 0);
      checkOutput("err_no_rd", memRead, 0);
      checkOutput("err_rv", respValid, 0);
      checkOutput("err_ready", reqReady, 1);
      checkOutput("err_data_hold", respData, lastData);
      @(negedge clk);
      checkOutput("err_one_cycle", respErr, 0);
    end else if (wr) begin
      checkOutput("st_mw", memWrite, 1);
      checkOutput("st_mr", memRead, 0);
      checkOutput("st_addr", memA, addr);
      checkOutput("st_wdata", memW, data);
      checkOutput("st_busy", reqReady, 0);
      checkOutput("st_early_done", wrDone, 0);
      refMem[int'(addr)] = data;
      @(negedge clk);
      checkOutput("st_done", wrDone, 1);
      checkOutput("st_mw_off", memWrite, 0);
      checkOutput("st_ready", reqReady, 1);
    end else begin
      checkOutput("ld_mr", memRead, 1);
      checkOutput("ld_mw", memWrite, 0);
      checkOutput("ld_addr", memA, addr);
      checkOutput("ld_busy", reqReady, 0);
      @(negedge clk);
      checkOutput("ld_mr_off", memRead, 0);
      checkOutput("ld_early_rv", respValid, 0);
      @(negedge clk);
      lastData = refMem[int'(addr)];
      checkOutput("ld_rv", respValid, 1);
      checkOutput("ld_data", respData, lastData);
      if (isBurst) begin
        checkOutput("b2_mr", memRead, !lastBeat);
        if (!lastBeat) checkOutput("b2_addr", memA, addr2);
        checkOutput("b2_busy", reqReady, 0);
        @(negedge clk);
        checkOutput("b2_gap_rv", respValid, 0);
        checkOutput("b2_gap_mr", memRead, 0);
        @(negedge clk);
        if (lastBeat) begin
          checkOutput("b2_err", respErr, 1);
          checkOutput("b2_err_rv", respValid, 0);
          checkOutput("b2_err_data", respData, lastData);
        end else begin
          lastData = refMem[int'(addr2)];
          checkOutput("b2_rv", respValid, 1);
          checkOutput("b2_data", respData, lastData);
        end
        checkOutput("b2_ready", reqReady, 1);
      end else begin
        checkOutput("ld_ready", reqReady, 1);
        checkOutput("ld_mr_idle", memRead, 0);
      end
    end
  endtask

  initial begin
    logic              wr;
    logic              burst;
    logic [ADDR_W-1:0] addr;
    int                pick;

    reset    = 1'b1;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqBurst = 1'b0;
    reqAddr  = '0;
    reqWdata = '0;
    lastData = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", reqReady, 1);
    checkOutput("rst_rv", respValid, 0);
    checkOutput("rst_wd", wrDone, 0);
    checkOutput("rst_err", respErr, 0);
    checkOutput("rst_mw", memWrite, 0);
    checkOutput("rst_mr", memRead, 0);
    checkOutput("rst_memA", memA, 0);
    checkOutput("rst_memW", memW, 0);
    checkOutput("rst_data", respData, 0);
    reset = 1'b0;
    @(negedge clk);
    checkQuiet("post_rst");

    applyStimulus(1'b1, 1'b0, 16'h0010, 16'hBEEF);
    applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'h0000);

    // Give every address the random phase may read a known value
    for (int i = 0; i < 33; i++) applyStimulus(1'b1, 1'b0, 16'(i), 16'($urandom));
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 16'hFFF0 + 16'(i), 16'($urandom));

    // Reset while a load sits in WAIT must suppress its response
    reqValid = 1'b1;
    reqWrite = 1'b0;
    reqBurst = 1'b0;
    reqAddr  = 16'h0010;
    checkOutput("abort_ready", reqReady, 1);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    @(negedge clk);
    checkOutput("abort_mr", memRead, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_rv", respValid, 0);
    checkOutput("abort_ready_after", reqReady, 1);
    checkOutput("abort_mr_off", memRead, 0);
    checkOutput("abort_mw_off", memWrite, 0);
    checkOutput("abort_data", respData, 0);
    reset    = 1'b0;
    lastData = '0;
    @(negedge clk);
    checkQuiet("abort_idle");

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        checkQuiet("gap");
      end
      pick  = int'($urandom_range(0, 9));
      wr    = 1'($urandom_range(0, 1));
      burst = 1'($urandom_range(0, 1));
      if (pick == 0)      addr = 16'hFFFF;
      else if (pick == 1) addr = 16'($urandom_range(16'hFFF0, 16'hFFFE));
      else                addr = 16'($urandom_range(0, 31));
      applyStimulus(wr, burst, addr, 16'($urandom));
    end

`ifdef MEM_BURST_EN
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h1010);
    applyStimulus(1'b1, 1'b0, 16'h0001, 16'h000A);
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'hFFFE, 16'h0000);
    applyStimulus(1'b1, 1'b1, 16'h0002, 16'h5A5A);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
